// File: rtl/sobel_pkg.sv
// rtl/sobel_pkg.sv - mode encodings and 3x3 Sobel kernel coefficients
package sobel_pkg;

    localparam logic [1:0] MODE_GX  = 2'b00;
    localparam logic [1:0] MODE_GY  = 2'b01;
    localparam logic [1:0] MODE_SUM = 2'b10;

    // Indexed [row][col]: row 0 is the oldest line, col 0 the oldest pixel.
    localparam int KGX [3][3] = '{'{-1, 0, 1}, '{-2, 0, 2}, '{-1, 0, 1}};
    localparam int KGY [3][3] = '{'{-1, -2, -1}, '{0, 0, 0}, '{1, 2, 1}};

endpackage

// File: rtl/line_buffer.sv
// rtl/line_buffer.sv - circular RAM delaying each enabled sample by DEPTH enables
module line_buffer #(
    parameter int DEPTH = 480,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             en_i,
    input  logic [WIDTH-1:0] din_i,
    output logic [WIDTH-1:0] dout_o
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    ptr_q;

    // Read-before-write at the same slot yields the sample from DEPTH enables ago.
    assign dout_o = mem_q[ptr_q];

    always_ff @(posedge clk) begin
        if (en_i) begin
            mem_q[ptr_q] <= din_i;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ptr_q <= '0;
        end else if (en_i) begin
            ptr_q <= (ptr_q == AW'(DEPTH - 1)) ? '0 : ptr_q + 1'b1;
        end
    end

endmodule

// File: rtl/sobel_stream.sv
// rtl/sobel_stream.sv - streaming 3x3 Sobel edge operator, 3-stage stallable pipeline
// SOBEL_THRESH_EN adds a per-frame binary threshold on the output magnitude.
module sobel_stream
    import sobel_pkg::*;
#(
    parameter int IMG_W = 480,
    parameter int IMG_H = 857,
    parameter int PIX_W = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       mode,
`ifdef SOBEL_THRESH_EN
    input  logic [PIX_W-1:0] thresh,
`endif
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [PIX_W-1:0] in_pixel,
    input  logic             in_sof,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [PIX_W-1:0] out_pixel,
    output logic             out_sof,
    output logic             out_eol
);
    localparam int GW = PIX_W + 4;
    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);

    logic advance, accept;
    assign advance  = !out_valid || out_ready;
    assign in_ready = advance;
    assign accept   = in_valid && advance;

    logic [CW-1:0] col_q, col_cur, col_d;
    logic [RW-1:0] row_q, row_cur, row_d;
    logic          frame_start, interior;
    logic [1:0]    mode_q, mode_cur;

    always_comb begin
        col_cur     = in_sof ? '0 : col_q;
        row_cur     = in_sof ? '0 : row_q;
        frame_start = (col_cur == '0) && (row_cur == '0);
        interior    = (col_cur >= CW'(2)) && (row_cur >= RW'(2));
        mode_cur    = frame_start ? mode : mode_q;
        col_d       = col_cur + 1'b1;
        row_d       = row_cur;
        if (col_cur == CW'(IMG_W - 1)) begin
            col_d = '0;
            row_d = (row_cur == RW'(IMG_H - 1)) ? '0 : row_cur + 1'b1;
        end
    end

    logic [PIX_W-1:0] lb0_out, lb1_out;

    line_buffer #(.DEPTH(IMG_W), .WIDTH(PIX_W)) u_lb0 (
        .clk(clk), .reset_n(reset_n), .en_i(accept), .din_i(in_pixel), .dout_o(lb0_out)
    );
    line_buffer #(.DEPTH(IMG_W), .WIDTH(PIX_W)) u_lb1 (
        .clk(clk), .reset_n(reset_n), .en_i(accept), .din_i(lb0_out), .dout_o(lb1_out)
    );

    logic [PIX_W-1:0] win_q [3][3];

    always_ff @(posedge clk) begin
        if (accept) begin
            for (int r = 0; r < 3; r++) begin
                win_q[r][0] <= win_q[r][1];
                win_q[r][1] <= win_q[r][2];
            end
            win_q[0][2] <= lb1_out;
            win_q[1][2] <= lb0_out;
            win_q[2][2] <= in_pixel;
        end
    end

    logic signed [GW-1:0] gx_d, gy_d, pix_s;

    always_comb begin
        gx_d  = '0;
        gy_d  = '0;
        pix_s = '0;
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
                pix_s = $signed({4'b0000, win_q[r][c]});
                gx_d  = gx_d + GW'(KGX[r][c]) * pix_s;
                gy_d  = gy_d + GW'(KGY[r][c]) * pix_s;
            end
        end
    end

`ifdef SOBEL_THRESH_EN
    logic [PIX_W-1:0] thresh_q, thresh_cur, s1_thresh_q, s2_thresh_q;
    assign thresh_cur = frame_start ? thresh : thresh_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            thresh_q    <= '0;
            s1_thresh_q <= '0;
            s2_thresh_q <= '0;
        end else if (advance) begin
            if (accept) begin
                thresh_q <= thresh_cur;
            end
            s1_thresh_q <= thresh_cur;
            s2_thresh_q <= s1_thresh_q;
        end
    end
`endif

    logic                 s1_valid_q, s1_sof_q, s1_eol_q;
    logic [1:0]           s1_mode_q, s2_mode_q;
    logic                 s2_valid_q, s2_sof_q, s2_eol_q;
    logic signed [GW-1:0] gx_q, gy_q;
    logic [GW-1:0]        ax, ay, mag;
    logic [PIX_W-1:0]     sat, pix_d;

    // Mode travels with each pixel so a frame boundary inside the pipe stays exact.
    always_comb begin
        ax  = gx_q[GW-1] ? -gx_q : gx_q;
        ay  = gy_q[GW-1] ? -gy_q : gy_q;
        mag = '0;
        case (s2_mode_q)
            MODE_GX:  mag = ax;
            MODE_GY:  mag = ay;
            MODE_SUM: mag = ax + ay;
            default:  mag = ax + ay;
        endcase
        sat = (|mag[GW-1:PIX_W]) ? '1 : mag[PIX_W-1:0];
`ifdef SOBEL_THRESH_EN
        pix_d = (sat >= s2_thresh_q) ? '1 : '0;
`else
        pix_d = sat;
`endif
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            col_q      <= '0;
            row_q      <= '0;
            mode_q     <= '0;
            s1_valid_q <= 1'b0;
            s1_sof_q   <= 1'b0;
            s1_eol_q   <= 1'b0;
            s1_mode_q  <= '0;
            s2_valid_q <= 1'b0;
            s2_sof_q   <= 1'b0;
            s2_eol_q   <= 1'b0;
            s2_mode_q  <= '0;
            gx_q       <= '0;
            gy_q       <= '0;
            out_valid  <= 1'b0;
            out_pixel  <= '0;
            out_sof    <= 1'b0;
            out_eol    <= 1'b0;
        end else if (advance) begin
            if (accept) begin
                col_q  <= col_d;
                row_q  <= row_d;
                mode_q <= mode_cur;
            end
            s1_valid_q <= accept && interior;
            s1_sof_q   <= accept && (row_cur == RW'(2)) && (col_cur == CW'(2));
            s1_eol_q   <= accept && interior && (col_cur == CW'(IMG_W - 1));
            s1_mode_q  <= mode_cur;
            s2_valid_q <= s1_valid_q;
            s2_sof_q   <= s1_sof_q;
            s2_eol_q   <= s1_eol_q;
            s2_mode_q  <= s1_mode_q;
            gx_q       <= gx_d;
            gy_q       <= gy_d;
            out_valid  <= s2_valid_q;
            out_pixel  <= pix_d;
            out_sof    <= s2_sof_q;
            out_eol    <= s2_eol_q;
        end
    end

endmodule

// File: tb/tb_sobel_stream.sv
// tb/tb_sobel_stream.sv - self-checking bench for sobel_stream with a frame-level reference model
module tb_sobel_stream;
    localparam int W    = 8;
    localparam int H    = 6;
    localparam int NPIX = W * H;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [1:0] mode = 2'b00;
    logic       in_valid = 1'b0;
    logic       in_sof = 1'b0;
    logic [7:0] in_pixel = 8'd0;
    logic       in_ready;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [7:0] out_pixel;
    logic       out_sof;
    logic       out_eol;
`ifdef SOBEL_THRESH_EN
    logic [7:0] thresh = 8'd0;
`endif

    int total = 0;
    int bad   = 0;
    bit stall_en = 1'b0;

    typedef struct packed {
        logic [7:0] pix;
        logic       sof;
        logic       eol;
    } item_t;

    item_t exp_q[$];
    item_t obs_q[$];
    int    img [H][W];
    bit    hold_pend = 1'b0;
    logic [10:0] hold_val = '0;

    sobel_stream #(.IMG_W(W), .IMG_H(H), .PIX_W(8)) dut (
        .clk(clk),
        .reset_n(reset_n),
        .mode(mode),
`ifdef SOBEL_THRESH_EN
        .thresh(thresh),
`endif
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_pixel(in_pixel),
        .in_sof(in_sof),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_pixel(out_pixel),
        .out_sof(out_sof),
        .out_eol(out_eol)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        out_ready = stall_en ? ($urandom_range(0, 1) == 1) : 1'b1;
    end

    always @(negedge clk) begin
        if (reset_n) begin
            if (out_valid && out_ready) obs_q.push_back(item_t'{out_pixel, out_sof, out_eol});
            total++;
            assert (in_ready === !(out_valid && !out_ready)) else begin
                bad++;
                $error("FAIL in_ready observed=%b expected=%b", in_ready, !(out_valid && !out_ready));
            end
            if (hold_pend) begin
                total++;
                assert ({out_valid, out_pixel, out_sof, out_eol} === hold_val) else begin
                    bad++;
                    $error("FAIL hold_stable observed=%h expected=%h",
                           {out_valid, out_pixel, out_sof, out_eol}, hold_val);
                end
            end
            hold_pend = out_valid && !out_ready;
            hold_val  = {out_valid, out_pixel, out_sof, out_eol};
        end else begin
            hold_pend = 1'b0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    // 0 uniform 100, 1 vertical step, 2 horizontal step, 3 random
    task automatic fill(input int kind);
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                case (kind)
                    0:       img[r][c] = 100;
                    1:       img[r][c] = (c >= 4) ? 200 : 0;
                    2:       img[r][c] = (r >= 3) ? 10 : 0;
                    default: img[r][c] = int'($urandom_range(0, 255));
                endcase
            end
        end
    endtask

    task automatic model(input int npix, input int md);
        int p [3][3];
        int gx, gy, m, r, c;
        for (int i = 0; i < npix; i++) begin
            r = i / W;
            c = i % W;
            if (r >= 2 && c >= 2) begin
                for (int a = 0; a < 3; a++)
                    for (int b = 0; b < 3; b++)
                        p[a][b] = img[r - 2 + a][c - 2 + b];
                gx = (p[0][2] + 2 * p[1][2] + p[2][2]) - (p[0][0] + 2 * p[1][0] + p[2][0]);
                gy = (p[2][0] + 2 * p[2][1] + p[2][2]) - (p[0][0] + 2 * p[0][1] + p[0][2]);
                if (gx < 0) gx = -gx;
                if (gy < 0) gy = -gy;
                m = (md == 0) ? gx : (md == 1) ? gy : gx + gy;
                if (m > 255) m = 255;
`ifdef SOBEL_THRESH_EN
                m = (m >= int'(thresh)) ? 255 : 0;
`endif
                exp_q.push_back(item_t'{8'(m), (r == 2 && c == 2), (c == W - 1)});
            end
        end
    endtask

    task automatic push(input logic [7:0] pix, input logic sof);
        bit acc = 1'b0;
        int guard = 0;
        in_valid = 1'b1;
        in_pixel = pix;
        in_sof   = sof;
        while (!acc) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            guard++;
            if (guard > 1000) begin
                $display("FAIL push_timeout observed=no_accept expected=accept");
                $fatal(1, "input stalled");
            end
        end
        in_valid = 1'b0;
        in_sof   = 1'b0;
    endtask

    task automatic send_frame(input int npix, input bit sof_first, input bit scramble);
        for (int i = 0; i < npix; i++) begin
            if (scramble && i == 7) mode = ~mode;
            push(8'(img[i / W][i % W]), sof_first && (i == 0));
        end
    endtask

    task automatic check_run(input string tag);
        int g = 0;
        while (obs_q.size() < exp_q.size() && g < 3000) begin
            @(posedge clk);
            #1;
            g++;
        end
        repeat (6) @(posedge clk);
        #1;
        chk({tag, "_count"}, obs_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            chk($sformatf("%s_pix%0d", tag, i), obs_q[i].pix, exp_q[i].pix);
            chk($sformatf("%s_sof%0d", tag, i), obs_q[i].sof, exp_q[i].sof);
            chk($sformatf("%s_eol%0d", tag, i), obs_q[i].eol, exp_q[i].eol);
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_pixel", out_pixel, 0);
        chk("rst_out_sof", out_sof, 0);
        chk("rst_out_eol", out_eol, 0);
        chk("rst_in_ready", in_ready, 1);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        fill(0); mode = 2'd0; model(NPIX, 0); send_frame(NPIX, 0, 0); check_run("uniform");
        fill(1); mode = 2'd0; model(NPIX, 0); send_frame(NPIX, 0, 0); check_run("vstep_gx");
        mode = 2'd1; model(NPIX, 1); send_frame(NPIX, 0, 0); check_run("vstep_gy");
        fill(2); mode = 2'd1; model(NPIX, 1); send_frame(NPIX, 0, 0); check_run("hstep_gy");
        mode = 2'd2; model(NPIX, 2); send_frame(NPIX, 0, 0); check_run("hstep_sum");

        stall_en = 1'b1;
        fill(3); mode = 2'd2; model(NPIX, 2); send_frame(NPIX, 0, 1);
        fill(3); mode = 2'd0; model(NPIX, 0); send_frame(NPIX, 0, 0);
        check_run("rand_stall");
        fill(3); mode = 2'd3; model(NPIX, 3); send_frame(NPIX, 0, 1); check_run("rand_mode3");

        stall_en = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        fill(3); mode = 2'd0;
        for (int i = 0; i < 20; i++) begin
            push(8'(img[i / W][i % W]), 1'b0);
            if (i == 19) chk("latency_e1", out_valid, 0);
        end
        @(posedge clk);
        #1;
        chk("latency_e2", out_valid, 1);
        reset_n = 1'b0;
        #1;
        chk("async_rst_valid", out_valid, 0);
        chk("async_rst_ready", in_ready, 1);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        obs_q.delete();
        exp_q.delete();
        fill(3); mode = 2'd2; model(NPIX, 2); send_frame(NPIX, 0, 0); check_run("after_reset");

        stall_en = 1'b1;
        fill(3); mode = 2'd1; model(30, 1); send_frame(30, 0, 0);
        fill(3); mode = 2'd2; model(NPIX, 2); send_frame(NPIX, 1, 0);
        check_run("resync");
        fill(3); mode = 2'd0; model(NPIX, 0); send_frame(NPIX, 0, 0); check_run("post_resync");

`ifdef SOBEL_THRESH_EN
        stall_en = 1'b0;
        fill(2); mode = 2'd1;
        thresh = 8'd50; model(NPIX, 1); send_frame(NPIX, 0, 0); check_run("thr50");
        thresh = 8'd40; model(NPIX, 1); send_frame(NPIX, 0, 0); check_run("thr40");
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
